// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module      : muldiv_pkg
// Description : Shared encodings and constants for the iterative mul/div unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

    // Default operand width; one iteration per operand bit
    localparam int ITER = 32;

    // Operation encodings carried on the op port
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
//------------------------------------------------------------------------------
// Module      : muldiv_signfix
// Description : Combinational sign correction turning unsigned magnitude
//               results into the final HI/LO values.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic [1:0]         op,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quo,
    input  logic [WIDTH-1:0]   rem,
    input  logic               div_zero,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic [2*WIDTH-1:0] w_prod_fix;
    logic               w_neg_prod;
    logic               w_neg_quo;
    logic               w_neg_rem;

    // Decide which results need negating and select the final HI/LO pair
    always_comb begin
        w_neg_prod = (op == OP_MULT) && (sign_a ^ sign_b);
        // A zero divisor leaves the quotient as all ones, never negated
        w_neg_quo  = (op == OP_DIV) && (sign_a ^ sign_b) && !div_zero;
        // Remainder follows the dividend; with a zero divisor this restores srca
        w_neg_rem  = (op == OP_DIV) && sign_a;
        w_prod_fix = w_neg_prod ? -prod : prod;
        if (op[1]) begin
            res_lo = w_neg_quo ? -quo : quo;
            res_hi = w_neg_rem ? -rem : rem;
        end else begin
            res_lo = w_prod_fix[WIDTH-1:0];
            res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO
//               registers; one result bit per clock, fixed latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div_zero;
    // Multiplicand (multiply) or divisor (divide) magnitude
    logic [WIDTH-1:0]   r_opb;
    // Low product half / multiplier bits (multiply) or quotient / dividend bits (divide)
    logic [WIDTH-1:0]   r_quo;
    // High product half (multiply) or partial remainder (divide)
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_launch;
    logic               w_idle_move;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH+1:0]   w_trial;
    logic               w_fits;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Decode launch and register moves; start takes priority over a move
    always_comb begin
        w_launch    = (r_state == IDLE) && start;
        w_idle_move = (r_state == IDLE) && !start;
        w_signed    = ~op[0];
        w_mag_a     = (w_signed && srca[WIDTH-1]) ? -srca : srca;
        w_mag_b     = (w_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    end

    // One shift-add step and one restoring-divide step, selected by r_op
    always_comb begin
        w_sum     = r_rem + {1'b0, (r_quo[0] ? r_opb : {WIDTH{1'b0}})};
        w_shifted = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_trial   = {1'b0, w_shifted} - {2'b00, r_opb};
        w_fits    = ~w_trial[WIDTH+1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_count == c_last) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered status outputs
    always_comb begin
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (r_state == FIX);
    end

    // Datapath: operand capture, iteration, result write-back and moves
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_op       <= OP_MULT;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_opb      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_op       <= op;
                        r_sign_a   <= srca[WIDTH-1];
                        r_sign_b   <= srcb[WIDTH-1];
                        r_div_zero <= (srcb == '0);
                        r_count    <= '0;
                        r_rem      <= '0;
                        if (op[1]) begin
                            r_opb <= w_mag_b;
                            r_quo <= w_mag_a;
                        end else begin
                            r_opb <= w_mag_a;
                            r_quo <= w_mag_b;
                        end
                    end else if (w_idle_move) begin
                        if (mthi) r_hi <= srca;
                        if (mtlo) r_lo <= srca;
                    end
                end
                RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_op[1]) begin
                        r_rem <= w_fits ? w_trial[WIDTH:0] : w_shifted;
                        r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    end else begin
                        r_rem <= {1'b0, w_sum[WIDTH:1]};
                        r_quo <= {w_sum[0], r_quo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    muldiv_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .op       (r_op),
        .sign_a   (r_sign_a),
        .sign_b   (r_sign_b),
        .prod     ({r_rem[WIDTH-1:0], r_quo}),
        .quo      (r_quo),
        .rem      (r_rem[WIDTH-1:0]),
        .div_zero (r_div_zero),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo)
    );

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one operation from a negedge, wait for done (bounded), check result.
    // Returns at the negedge where done is high so the next call starts back-to-back.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit with_mthi, input bit disturb);
        int n;
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        mthi  = with_mthi;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        check_val({tag, " busy after start"}, {31'b0, busy}, 32'd1);
        if (with_mthi) check_val({tag, " mthi dropped on start"}, hi, 32'h12345678);
        n = 0;
        while (!done && n < 40) begin
            if (disturb && n == 5) begin
                start = 1'b1;
                mtlo  = 1'b1;
                srca  = 32'hDEADBEEF;
                srcb  = 32'd9;
            end
            if (disturb && n == 6) begin
                start = 1'b0;
                mtlo  = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check_val({tag, " cycles to done"}, n, 32'd33);
        check_val({tag, " busy at done"}, {31'b0, busy}, 32'd0);
        check_val({tag, " hi"}, hi, eh);
        check_val({tag, " lo"}, lo, el);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        srca  = '0;
        srcb  = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset busy", {31'b0, busy}, 32'd0);
        check_val("reset done", {31'b0, done}, 32'd0);
        check_val("reset hi", hi, 32'd0);
        check_val("reset lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("MULTU max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_op("MULT -3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op("DIVU 7/2 b2b", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0);
        run_op("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("DIV -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Both moves together, then mthi alone
        mthi = 1'b1;
        mtlo = 1'b1;
        srca = 32'hA5A5A5A5;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check_val("mthi+mtlo hi", hi, 32'hA5A5A5A5);
        check_val("mthi+mtlo lo", lo, 32'hA5A5A5A5);
        check_val("mthi+mtlo done", {31'b0, done}, 32'd0);
        mthi = 1'b1;
        srca = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0;
        check_val("mthi hi", hi, 32'h12345678);
        check_val("mthi lo kept", lo, 32'hA5A5A5A5);
        check_val("mthi done", {31'b0, done}, 32'd0);

        // start with a simultaneous mthi, then start/mtlo/operand changes while busy
        run_op("MULTU 3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, 1'b1);

        // Reset in the middle of a divide
        op    = OP_DIVU;
        srca  = 32'd100;
        srcb  = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_val("pre-reset busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mid reset busy", {31'b0, busy}, 32'd0);
        check_val("mid reset done", {31'b0, done}, 32'd0);
        check_val("mid reset hi", hi, 32'd0);
        check_val("mid reset lo", lo, 32'd0);

        run_op("MULTU 2x2", OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        check_val("done one cycle", {31'b0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
